// File: rtl/input_conditioner.sv
// Board input conditioner: two-flop synchronizers and per-bit debounce
// for SW/KEY, plus registered key press/release and switch-change strobes.
//
// Ports:
//   CLOCK_50    in   system clock, all state on rising edge
//   Resetn      in   synchronous active-low reset
//   SW          in   raw switch levels (asynchronous)
//   KEY         in   raw pushbutton levels, 0 = pressed (asynchronous)
//   sw_db       out  debounced switch levels
//   key_db      out  debounced key levels, active-low like KEY
//   key_press   out  one-cycle strobe on key_db[i] 1->0
//   key_release out  one-cycle strobe on key_db[i] 0->1
//   sw_changed  out  one-cycle strobe when any sw_db bit updates
module input_conditioner #(
  parameter int N_SW            = 10,
  parameter int N_KEY           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic             CLOCK_50,
  input  logic             Resetn,
  input  logic [N_SW-1:0]  SW,
  input  logic [N_KEY-1:0] KEY,
  output logic [N_SW-1:0]  sw_db,
  output logic [N_KEY-1:0] key_db,
  output logic [N_KEY-1:0] key_press,
  output logic [N_KEY-1:0] key_release,
  output logic             sw_changed
);

  // Terminal count: a mismatch seen on this count commits the new level.
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  // Synchronizers
  logic [N_SW-1:0]  sw_s1_q, sw_s1_d;
  logic [N_SW-1:0]  sw_s2_q, sw_s2_d;
  logic [N_KEY-1:0] key_s1_q, key_s1_d;
  logic [N_KEY-1:0] key_s2_q, key_s2_d;

  // Debounce state
  logic [N_SW-1:0]  sw_db_q, sw_db_d;
  logic [N_KEY-1:0] key_db_q, key_db_d;
  logic [CNT_W-1:0] sw_cnt_q  [N_SW];
  logic [CNT_W-1:0] sw_cnt_d  [N_SW];
  logic [CNT_W-1:0] key_cnt_q [N_KEY];
  logic [CNT_W-1:0] key_cnt_d [N_KEY];

  // Strobes
  logic [N_KEY-1:0] key_press_q, key_press_d;
  logic [N_KEY-1:0] key_release_q, key_release_d;
  logic             sw_changed_q, sw_changed_d;

  always_comb begin
    sw_s1_d  = SW;
    sw_s2_d  = sw_s1_q;
    key_s1_d = KEY;
    key_s2_d = key_s1_q;

    sw_db_d = sw_db_q;
    for (int i = 0; i < N_SW; i++) begin
      sw_cnt_d[i] = '0;
      if (sw_s2_q[i] != sw_db_q[i]) begin
        if (sw_cnt_q[i] == CNT_MAX) begin
          sw_db_d[i] = sw_s2_q[i];
        end else begin
          sw_cnt_d[i] = sw_cnt_q[i] + 1'b1;
        end
      end
    end

    key_db_d = key_db_q;
    for (int i = 0; i < N_KEY; i++) begin
      key_cnt_d[i] = '0;
      if (key_s2_q[i] != key_db_q[i]) begin
        if (key_cnt_q[i] == CNT_MAX) begin
          key_db_d[i] = key_s2_q[i];
        end else begin
          key_cnt_d[i] = key_cnt_q[i] + 1'b1;
        end
      end
    end

    // Strobes are registered alongside the new level, so they line up
    // with the first cycle the updated value is visible.
    sw_changed_d  = |(sw_db_d ^ sw_db_q);
    key_press_d   = key_db_q & ~key_db_d;
    key_release_d = ~key_db_q & key_db_d;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      sw_s1_q       <= '0;
      sw_s2_q       <= '0;
      key_s1_q      <= '1;
      key_s2_q      <= '1;
      sw_db_q       <= '0;
      key_db_q      <= '1;
      for (int i = 0; i < N_SW; i++) sw_cnt_q[i] <= '0;
      for (int i = 0; i < N_KEY; i++) key_cnt_q[i] <= '0;
      key_press_q   <= '0;
      key_release_q <= '0;
      sw_changed_q  <= 1'b0;
    end else begin
      sw_s1_q       <= sw_s1_d;
      sw_s2_q       <= sw_s2_d;
      key_s1_q      <= key_s1_d;
      key_s2_q      <= key_s2_d;
      sw_db_q       <= sw_db_d;
      key_db_q      <= key_db_d;
      for (int i = 0; i < N_SW; i++) sw_cnt_q[i] <= sw_cnt_d[i];
      for (int i = 0; i < N_KEY; i++) key_cnt_q[i] <= key_cnt_d[i];
      key_press_q   <= key_press_d;
      key_release_q <= key_release_d;
      sw_changed_q  <= sw_changed_d;
    end
  end

  assign sw_db       = sw_db_q;
  assign key_db      = key_db_q;
  assign key_press   = key_press_q;
  assign key_release = key_release_q;
  assign sw_changed  = sw_changed_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner with DEBOUNCE_CYCLES=4: per-edge vector
// table with hand-derived expectations, checked through a scoreboard queue.
module tb_input_conditioner;

  logic       clk;
  logic       rstn;
  logic [9:0] sw;
  logic [3:0] key;
  logic [9:0] sw_db;
  logic [3:0] key_db;
  logic [3:0] key_press;
  logic [3:0] key_release;
  logic       sw_changed;

  input_conditioner #(
    .N_SW(10),
    .N_KEY(4),
    .DEBOUNCE_CYCLES(4),
    .CNT_W(3)
  ) dut (
    .CLOCK_50(clk),
    .Resetn(rstn),
    .SW(sw),
    .KEY(key),
    .sw_db(sw_db),
    .key_db(key_db),
    .key_press(key_press),
    .key_release(key_release),
    .sw_changed(sw_changed)
  );

  typedef struct {
    logic       r;
    logic [9:0] sw;
    logic [3:0] key;
    logic [9:0] esw;
    logic [3:0] ekey;
    logic [3:0] epr;
    logic [3:0] erl;
    logic       ech;
    string      tag;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done = 0;

  initial clk = 1'b0;
  always #10 clk = ~clk;

  function automatic void add(string tag, logic r, logic [9:0] s,
                              logic [3:0] k, logic [9:0] es,
                              logic [3:0] ek, logic [3:0] ep,
                              logic [3:0] er, logic ec);
    vec_t v;
    v.tag = tag; v.r = r; v.sw = s; v.key = k;
    v.esw = es; v.ekey = ek; v.epr = ep; v.erl = er; v.ech = ec;
    tbl.push_back(v);
  endfunction

  function automatic void hold(string tag, int n, logic r,
                               logic [9:0] s, logic [3:0] k,
                               logic [9:0] es, logic [3:0] ek);
    for (int i = 0; i < n; i++) add(tag, r, s, k, es, ek, 4'h0, 4'h0, 1'b0);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, want, $time);
    end
  endtask

  // Each vector is driven on a falling edge; its expectation is the
  // output state right after the following rising edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      vec_t e;
      e = exp_q.pop_front();
      chk({e.tag, ".sw_db"},       32'(sw_db),       32'(e.esw));
      chk({e.tag, ".key_db"},      32'(key_db),      32'(e.ekey));
      chk({e.tag, ".key_press"},   32'(key_press),   32'(e.epr));
      chk({e.tag, ".key_release"}, 32'(key_release), 32'(e.erl));
      chk({e.tag, ".sw_changed"},  32'(sw_changed),  32'(e.ech));
    end
  end

  initial begin
    logic [3:0] bounce [10];
    bounce = '{4'hF, 4'hE, 4'hF, 4'hE, 4'hE, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};

    // reset with inputs away from reset values
    hold("rst", 2, 0, 10'h3FF, 4'h0, 10'h000, 4'hF);
    hold("idle", 2, 1, 10'h000, 4'hF, 10'h000, 4'hF);
    // clean switch change, 6-edge latency
    hold("sw", 5, 1, 10'h2A5, 4'hF, 10'h000, 4'hF);
    add("sw", 1, 10'h2A5, 4'hF, 10'h2A5, 4'hF, 4'h0, 4'h0, 1'b1);
    hold("sw", 2, 1, 10'h2A5, 4'hF, 10'h2A5, 4'hF);
    // bounce on KEY[0]
    for (int i = 0; i < 10; i++)
      hold("bounce", 1, 1, 10'h2A5, bounce[i], 10'h2A5, 4'hF);
    // press then release of keys 0 and 3
    hold("press", 5, 1, 10'h2A5, 4'h6, 10'h2A5, 4'hF);
    add("press", 1, 10'h2A5, 4'h6, 10'h2A5, 4'h6, 4'h9, 4'h0, 1'b0);
    hold("press", 4, 1, 10'h2A5, 4'h6, 10'h2A5, 4'h6);
    hold("rel", 5, 1, 10'h2A5, 4'hF, 10'h2A5, 4'h6);
    add("rel", 1, 10'h2A5, 4'hF, 10'h2A5, 4'hF, 4'h0, 4'h9, 1'b0);
    hold("rel", 2, 1, 10'h2A5, 4'hF, 10'h2A5, 4'hF);
    // reset mid-debounce with SW[3] held
    hold("midrst", 3, 1, 10'h2AD, 4'hF, 10'h2A5, 4'hF);
    hold("midrst", 1, 0, 10'h2AD, 4'hF, 10'h000, 4'hF);
    hold("midrst", 5, 1, 10'h2AD, 4'hF, 10'h000, 4'hF);
    add("midrst", 1, 10'h2AD, 4'hF, 10'h2AD, 4'hF, 4'h0, 4'h0, 1'b1);
    hold("midrst", 2, 1, 10'h2AD, 4'hF, 10'h2AD, 4'hF);
    // simultaneous SW[0] and KEY[2]
    hold("simul", 5, 1, 10'h2AC, 4'hB, 10'h2AD, 4'hF);
    add("simul", 1, 10'h2AC, 4'hB, 10'h2AC, 4'hB, 4'h4, 4'h0, 1'b1);
    hold("simul", 2, 1, 10'h2AC, 4'hB, 10'h2AC, 4'hB);
    hold("simrel", 5, 1, 10'h2AC, 4'hF, 10'h2AC, 4'hB);
    add("simrel", 1, 10'h2AC, 4'hF, 10'h2AC, 4'hF, 4'h0, 4'h4, 1'b0);
    hold("simrel", 2, 1, 10'h2AC, 4'hF, 10'h2AC, 4'hF);
    // boundary: 3-cycle pulse rejected
    hold("pulse3", 3, 1, 10'h2AC, 4'hD, 10'h2AC, 4'hF);
    hold("pulse3", 6, 1, 10'h2AC, 4'hF, 10'h2AC, 4'hF);
    // boundary: 4-cycle pulse accepted, then released
    hold("pulse4", 4, 1, 10'h2AC, 4'hD, 10'h2AC, 4'hF);
    hold("pulse4", 1, 1, 10'h2AC, 4'hF, 10'h2AC, 4'hF);
    add("pulse4", 1, 10'h2AC, 4'hF, 10'h2AC, 4'hD, 4'h2, 4'h0, 1'b0);
    hold("pulse4", 3, 1, 10'h2AC, 4'hF, 10'h2AC, 4'hD);
    add("pulse4", 1, 10'h2AC, 4'hF, 10'h2AC, 4'hF, 4'h0, 4'h2, 1'b0);
    hold("pulse4", 2, 1, 10'h2AC, 4'hF, 10'h2AC, 4'hF);

    rstn = 1'b0;
    sw   = 10'h3FF;
    key  = 4'h0;

    foreach (tbl[i]) begin
      @(negedge clk);
      rstn = tbl[i].r;
      sw   = tbl[i].sw;
      key  = tbl[i].key;
      exp_q.push_back(tbl[i]);
    end
    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain left %0d want 0", exp_q.size());
    end
    done = 1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    if (!done) begin
      $display("FAIL timeout done %0d want 1", done);
      $fatal(1, "timeout");
    end
  end

endmodule
